// File: rtl/scope_trace_arbiter.sv
// Arbitrates a double-banked single-port trace RAM between the display fetch (absolute
// priority) and the acquisition writer, swapping banks only at frame start after a commit.
module scope_trace_arbiter #(
    parameter int DW    = 8,
    parameter int AW    = 9,
    parameter int DEPTH = 480
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_de,
    input  logic [15:0]   i_x,
    input  logic          i_vsync,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    input  logic          i_wr_req,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_wr_done,
    output logic          o_wr_ack,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW:0]   o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_front_bank,
    output logic          o_committed,
    output logic          o_swap
);

    typedef enum logic {FILL, COMMITTED} state_t;

    state_t state;
    logic   vs_prev;
    logic   front_bank;
    logic   vs_fall;
    logic   rd_go;
    logic   wr_ack;
    logic   wr_go;
    logic   vld_p1;
    logic   vld_p2;

    assign vs_fall = vs_prev & ~i_vsync;
    assign rd_go   = i_de & (32'(i_x) < DEPTH);
    // Display owns every i_de cycle, so rd_go and wr_go are mutually exclusive.
    assign wr_ack  = i_wr_req & ~i_de & (state == FILL);
    assign wr_go   = wr_ack & (32'(i_wr_addr) < DEPTH);

    assign o_wr_ack     = wr_ack;
    assign o_front_bank = front_bank;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= FILL;
            front_bank  <= 1'b0;
            vs_prev     <= 1'b1;
            o_committed <= 1'b0;
            o_swap      <= 1'b0;
        end else begin
            vs_prev <= i_vsync;
            o_swap  <= 1'b0;
            case (state)
                FILL: begin
                    if (i_wr_done) begin
                        state       <= COMMITTED;
                        o_committed <= 1'b1;
                    end
                end
                COMMITTED: begin
                    if (vs_fall) begin
                        state       <= FILL;
                        o_committed <= 1'b0;
                        front_bank  <= ~front_bank;
                        o_swap      <= 1'b1;
                    end
                end
                default: begin
                    state       <= FILL;
                    o_committed <= 1'b0;
                end
            endcase
        end
    end

    // p1: RAM command issue
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            vld_p1      <= 1'b0;
        end else begin
            o_mem_en <= rd_go | wr_go;
            o_mem_we <= wr_go;
            vld_p1   <= rd_go;
            if (rd_go) begin
                o_mem_addr <= {front_bank, i_x[AW-1:0]};
            end else if (wr_go) begin
                o_mem_addr  <= {~front_bank, i_wr_addr};
                o_mem_wdata <= i_wr_data;
            end
        end
    end

    // p2: RAM data returning; p3: registered to the display
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p2     <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            vld_p2     <= vld_p1;
            o_rd_valid <= vld_p2;
            o_rd_data  <= vld_p2 ? i_mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_scope_trace_arbiter.sv
// Randomized bench for scope_trace_arbiter: a cycle-scheduled reference model predicts every
// output from the arbitration rules, alongside directed frame/commit/stall scenarios.
module tb_scope_trace_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 480;
    localparam int NE    = 8192;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_de;
    logic [15:0]   i_x;
    logic          i_vsync;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic          i_wr_req;
    logic [AW-1:0] i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_wr_done;
    logic          o_wr_ack;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW:0]   o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          o_front_bank;
    logic          o_committed;
    logic          o_swap;

    scope_trace_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_de         (i_de),
        .i_x          (i_x),
        .i_vsync      (i_vsync),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .i_wr_req     (i_wr_req),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_wr_done    (i_wr_done),
        .o_wr_ack     (o_wr_ack),
        .o_mem_en     (o_mem_en),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_front_bank (o_front_bank),
        .o_committed  (o_committed),
        .o_swap       (o_swap)
    );

    always #5 i_clk = ~i_clk;

    // Single-port synchronous RAM with a bench-side preload port.
    logic [DW-1:0] ram [0:1023];
    logic          pl_en;
    logic [9:0]    pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge i_clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (o_mem_en) begin
            if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
            else          i_mem_rdata     <= ram[o_mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural state plus a per-cycle schedule of expected outputs.
    logic [DW-1:0] ref_mem [0:1023];
    bit            m_front, m_committed, m_vs_prev;
    bit            last_ack;
    int            cyc;
    bit            exp_en [NE];
    bit            exp_we [NE];
    logic [AW:0]   exp_addr [NE];
    logic [DW-1:0] exp_wdata [NE];
    bit            exp_rv [NE];
    logic [DW-1:0] exp_rd [NE];
    bit            exp_fb [NE];
    bit            exp_cm [NE];
    bit            exp_sw [NE];

    task automatic init_model();
        for (int i = 0; i < NE; i++) begin
            exp_en[i] = 0; exp_we[i] = 0; exp_addr[i] = '0; exp_wdata[i] = '0;
            exp_rv[i] = 0; exp_rd[i] = '0; exp_fb[i] = 0; exp_cm[i] = 0; exp_sw[i] = 0;
        end
        m_front = 0; m_committed = 0; m_vs_prev = 1; cyc = 0; last_ack = 0;
    endtask

    // Advance one clock with the inputs currently driven; check everything the model predicts.
    task automatic tick();
        bit         ack_m, vs_fall_m;
        logic [9:0] a;
        int         n;
        #1;
        ack_m = i_wr_req && !i_de && !m_committed;
        check("wr_ack", 32'(o_wr_ack), 32'(ack_m));
        n = cyc + 1;
        exp_en[n] = 0; exp_we[n] = 0;
        exp_addr[n] = exp_addr[cyc]; exp_wdata[n] = exp_wdata[cyc];
        exp_rv[cyc+3] = 0; exp_rd[cyc+3] = '0;
        if (i_de) begin
            if (32'(i_x) < DEPTH) begin
                a = {m_front, i_x[8:0]};
                exp_en[n] = 1; exp_addr[n] = a;
                exp_rv[cyc+3] = 1; exp_rd[cyc+3] = ref_mem[a];
            end
        end else if (ack_m && 32'(i_wr_addr) < DEPTH) begin
            a = {~m_front, i_wr_addr};
            exp_en[n] = 1; exp_we[n] = 1; exp_addr[n] = a; exp_wdata[n] = i_wr_data;
            ref_mem[a] = i_wr_data;
        end
        vs_fall_m = m_vs_prev && !i_vsync;
        exp_sw[n] = 0;
        if (m_committed) begin
            if (vs_fall_m) begin
                m_front = !m_front; m_committed = 0; exp_sw[n] = 1;
            end
        end else if (i_wr_done) m_committed = 1;
        m_vs_prev = i_vsync;
        exp_fb[n] = m_front; exp_cm[n] = m_committed;
        last_ack = ack_m;
        @(posedge i_clk); #1;
        cyc++;
        check("mem_en",     32'(o_mem_en),     32'(exp_en[cyc]));
        check("mem_we",     32'(o_mem_we),     32'(exp_we[cyc]));
        check("mem_addr",   32'(o_mem_addr),   32'(exp_addr[cyc]));
        check("mem_wdata",  32'(o_mem_wdata),  32'(exp_wdata[cyc]));
        check("rd_valid",   32'(o_rd_valid),   32'(exp_rv[cyc]));
        check("rd_data",    32'(o_rd_data),    32'(exp_rd[cyc]));
        check("front_bank", 32'(o_front_bank), 32'(exp_fb[cyc]));
        check("committed",  32'(o_committed),  32'(exp_cm[cyc]));
        check("swap",       32'(o_swap),       32'(exp_sw[cyc]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"},  32'(o_rd_valid),   0);
        check({tag, "_rd_data"},   32'(o_rd_data),    0);
        check({tag, "_mem_en"},    32'(o_mem_en),     0);
        check({tag, "_mem_we"},    32'(o_mem_we),     0);
        check({tag, "_mem_addr"},  32'(o_mem_addr),   0);
        check({tag, "_mem_wdata"}, 32'(o_mem_wdata),  0);
        check({tag, "_front"},     32'(o_front_bank), 0);
        check({tag, "_committed"}, 32'(o_committed),  0);
        check({tag, "_swap"},      32'(o_swap),       0);
        check({tag, "_wr_ack"},    32'(o_wr_ack),     0);
    endtask

    task automatic random_cycles(input int count);
        bit pend;
        pend = i_wr_req;
        for (int i = 0; i < count; i++) begin
            if ($urandom % 8 == 0) i_de = ~i_de;
            i_x = ($urandom % 16 == 0) ? 16'($urandom) : 16'($urandom % 560);
            if ($urandom % 40 == 0) i_vsync = ~i_vsync;
            i_wr_done = ($urandom % 30 == 0);
            if (!pend && ($urandom % 3 == 0)) begin
                pend      = 1;
                i_wr_addr = ($urandom % 8 == 0) ? AW'(DEPTH + $urandom % 32) : AW'($urandom % DEPTH);
                i_wr_data = DW'($urandom);
            end
            i_wr_req = pend;
            tick();
            if (last_ack) pend = 0;
        end
        i_wr_req = 0; i_wr_done = 0; i_de = 0; i_vsync = 1;
    endtask

    initial begin
        logic [DW-1:0] v;
        i_rst_n = 0; i_de = 0; i_x = '0; i_vsync = 1; i_wr_req = 0;
        i_wr_addr = '0; i_wr_data = '0; i_wr_done = 0;
        pl_en = 0; pl_addr = '0; pl_data = '0;

        for (int i = 0; i < 1024; i++) begin
            v = (i == 5) ? 8'h3C : DW'($urandom);
            ref_mem[i] = v;
            pl_addr = 10'(i); pl_data = v; pl_en = 1;
            @(posedge i_clk); #2;
        end
        pl_en = 0;
        check_all_zero("por");
        i_rst_n = 1;
        init_model();

        // Read latency from bank 0, word 5.
        i_de = 1; i_x = 16'd5;
        tick();
        check("lat_en", 32'(o_mem_en), 1);
        check("lat_we", 32'(o_mem_we), 0);
        check("lat_addr", 32'(o_mem_addr), 32'h005);
        i_de = 0;
        tick();
        tick();
        check("lat_valid", 32'(o_rd_valid), 1);
        check("lat_data", 32'(o_rd_data), 32'h3C);

        // Write held off by 20 cycles of display enable.
        i_wr_req = 1; i_wr_addr = 9'd10; i_wr_data = 8'hA5; i_de = 1;
        for (int i = 0; i < 20; i++) begin
            i_x = 16'($urandom % 600);
            #1;
            check("stall_ack", 32'(o_wr_ack), 0);
            tick();
        end
        i_de = 0;
        #1;
        check("stall_release_ack", 32'(o_wr_ack), 1);
        tick();
        i_wr_req = 0;
        check("stall_we", 32'(o_mem_we), 1);
        check("stall_addr", 32'(o_mem_addr), 32'h20A);
        check("stall_wdata", 32'(o_mem_wdata), 32'hA5);

        // Commit, stalled write, swap at vsync fall.
        i_wr_done = 1;
        tick();
        i_wr_done = 0;
        check("commit", 32'(o_committed), 1);
        i_wr_req = 1; i_wr_addr = 9'd20; i_wr_data = 8'h5A;
        for (int i = 0; i < 4; i++) tick();
        check("commit_front_hold", 32'(o_front_bank), 0);
        i_vsync = 0;
        tick();
        check("swap_pulse", 32'(o_swap), 1);
        check("swap_front", 32'(o_front_bank), 1);
        check("swap_committed", 32'(o_committed), 0);
        #1;
        check("swap_ack", 32'(o_wr_ack), 1);
        tick();
        i_wr_req = 0;
        check("swap_wr_addr", 32'(o_mem_addr), 32'h014);
        check("swap_pulse_end", 32'(o_swap), 0);
        tick();
        i_vsync = 1;
        tick(); tick();

        // Commit and vsync fall in the same FILL cycle: swap deferred a frame.
        i_wr_done = 1; i_vsync = 0;
        tick();
        i_wr_done = 0;
        check("coinc_committed", 32'(o_committed), 1);
        check("coinc_no_swap", 32'(o_swap), 0);
        for (int i = 0; i < 5; i++) tick();
        i_vsync = 1;
        tick(); tick();
        check("coinc_front_hold", 32'(o_front_bank), 1);
        i_vsync = 0;
        tick();
        check("coinc_late_swap", 32'(o_swap), 1);
        check("coinc_front", 32'(o_front_bank), 0);
        i_vsync = 1;
        tick();

        // Out-of-range read column and write address.
        i_de = 1; i_x = 16'd480;
        tick();
        check("oor_rd_en", 32'(o_mem_en), 0);
        i_de = 0;
        tick(); tick();
        check("oor_rd_valid", 32'(o_rd_valid), 0);
        i_wr_req = 1; i_wr_addr = 9'd500; i_wr_data = 8'h77;
        #1;
        check("oor_wr_ack", 32'(o_wr_ack), 1);
        tick();
        i_wr_req = 0;
        check("oor_wr_en", 32'(o_mem_en), 0);
        tick();

        random_cycles(3000);

        // Asynchronous reset mid-frame with a commit pending and reads in flight.
        tick(); tick();
        i_wr_done = 1;
        tick();
        i_wr_done = 0;
        check("pre_rst_committed", 32'(o_committed), 1);
        i_de = 1; i_x = 16'd7;
        tick();
        i_x = 16'd8;
        tick();
        i_de = 0;
        #1;
        i_rst_n = 0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(posedge i_clk);
        #2;
        i_rst_n = 1;
        init_model();
        i_wr_req = 1; i_wr_addr = 9'd3; i_wr_data = 8'hC3;
        #1;
        check("post_rst_fill_ack", 32'(o_wr_ack), 1);
        tick();
        i_wr_req = 0;
        random_cycles(600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
